// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program-load path.
// Holds the RAM geometry, the loader FSM state type and the opcode constants
// that the control sequencer also uses.
package sap_pkg;

  localparam int unsigned SAP_ADDR_W = 4;
  localparam int unsigned SAP_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam logic [3:0] OP_MOV_A = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_XCHG  = 4'h2;
  localparam logic [3:0] OP_OUT   = 4'hE;

  // States in which a frame is being received and the idle timeout runs.
  function automatic logic is_frame_state(input loader_state_t s);
    return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/ram_stage_buf.sv
// Staging buffer for an incoming frame's data bytes.
// Ports:
//   clk       clock, writes on posedge
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_raddr   read address (asynchronous read)
//   o_rdata   read data
module ram_stage_buf #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_program_loader.sv
// Writer side of the program RAM: receives a framed byte stream
// (SYNC, ADDR, LEN, LEN data bytes, CSUM), stages and checksums it, then
// commits it into RAM one word per cycle. Holds the CPU in reset while a
// frame is in flight.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   in_data    host byte
//   in_valid   host byte valid
//   in_ready   loader accepts byte (transfer = in_valid & in_ready)
//   ram_we     RAM write strobe
//   ram_addr   RAM write address
//   ram_wdata  RAM write data
//   cpu_reset  active-low CPU hold (0 = CPU held)
//   done       one-cycle pulse, frame committed
//   error      one-cycle pulse, frame rejected (RAM untouched)
module ram_program_loader
  import sap_pkg::*;
#(
  parameter int unsigned       ADDR_W      = SAP_ADDR_W,
  parameter int unsigned       DATA_W      = SAP_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = 8'hA5,
  parameter int unsigned       TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0]   IDX_ONE  = 1;
  localparam logic [DATA_W-1:0] DEPTH_B  = DATA_W'(2**ADDR_W);
  localparam logic [31:0]       TMO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;
  logic [DATA_W-1:0] r_sum;
  logic [31:0]       r_tmo;

  logic              w_accept;
  logic              w_buf_we;
  logic              w_tmo_hit;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  assign w_accept  = in_valid & in_ready;
  assign w_buf_we  = w_accept && (r_state == ST_DATA);
  // During CSUM the first word is pre-read so the commit starts the next cycle;
  // during COMMIT r_idx already points at the word to be written next.
  assign w_rd_addr = (r_state == ST_CSUM) ? '0 : r_idx[ADDR_W-1:0];
  assign w_tmo_hit = (TIMEOUT_CYC != 0) && is_frame_state(r_state) && !w_accept
                     && (r_tmo == TMO_LAST);

  ram_stage_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (r_idx[ADDR_W-1:0]),
    .i_wdata (in_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_start   <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_tmo     <= '0;
      in_ready  <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done   <= 1'b0;
      error  <= 1'b0;
      ram_we <= 1'b0;

      if (is_frame_state(r_state) && !w_accept) r_tmo <= r_tmo + 32'd1;
      else                                      r_tmo <= '0;

      if (w_tmo_hit) begin
        r_state  <= ST_ERR;
        error    <= 1'b1;
        in_ready <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept && (in_data == SYNC_BYTE)) begin
              r_state   <= ST_ADDR;
              cpu_reset <= 1'b0;
            end
          end
          ST_ADDR: begin
            if (w_accept) begin
              r_start <= in_data[ADDR_W-1:0];
              r_state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (w_accept) begin
              if ((in_data == '0) || (in_data > DEPTH_B)) begin
                r_state  <= ST_ERR;
                error    <= 1'b1;
                in_ready <= 1'b0;
              end else begin
                r_len   <= in_data[ADDR_W:0];
                r_idx   <= '0;
                r_sum   <= '0;
                r_state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (w_accept) begin
              r_sum <= r_sum + in_data;
              if ((r_idx + IDX_ONE) == r_len) r_state <= ST_CSUM;
              else                            r_idx   <= r_idx + IDX_ONE;
            end
          end
          ST_CSUM: begin
            if (w_accept) begin
              in_ready <= 1'b0;
              if (in_data == r_sum) begin
                r_state   <= ST_COMMIT;
                ram_we    <= 1'b1;
                ram_addr  <= r_start;
                ram_wdata <= w_rd_data;
                r_idx     <= IDX_ONE;
              end else begin
                r_state <= ST_ERR;
                error   <= 1'b1;
              end
            end
          end
          ST_COMMIT: begin
            if (r_idx == r_len) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              ram_we    <= 1'b1;
              ram_addr  <= r_start + r_idx[ADDR_W-1:0];
              ram_wdata <= w_rd_data;
              r_idx     <= r_idx + IDX_ONE;
            end
          end
          ST_DONE, ST_ERR: begin
            r_state   <= ST_IDLE;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
          end
          default: begin
            r_state   <= ST_IDLE;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
